uart_rx: RTL

Parameterised UART receiver, 8N1, LSB first: the receive counterpart of the team's `uart_tx`, sharing its `CLK_FREQ`/`BAUD` parameterisation.
- Synchronises the asynchronous `rx` line, validates the start bit and samples each bit at mid-bit.
- Presents each received byte with a one-cycle `valid` pulse and flags bad stop bits.
- Sits between the board RX pin and command/loopback logic in the fabric.

---
 rtl/uart_rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, sampling each bit at mid-bit with a CLK_FREQ/BAUD divider.
// Build with UART_RX_MAJORITY_EN defined to take each bit as a 3-sample majority of the synchronised line.
module uart_rx #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned BAUD_DIV  = CLK_FREQ / BAUD;
   localparam int unsigned HALF      = BAUD_DIV / 2;
   localparam logic [15:0] DIV_LAST  = 16'(BAUD_DIV - 1);
   localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

   generate
      if (BAUD_DIV < 4 || BAUD_DIV > 65535) begin : g_bad_div
         $error("uart_rx: CLK_FREQ/BAUD must lie in 4..65535");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_e;

   state_e      state_q, state_d;
   logic        rx_m_q, rx_s_q;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        bit_s;

`ifdef UART_RX_MAJORITY_EN
   // hist_q[0] mirrors rx_s_q, so the vote covers the current and two previous synchronised samples.
   logic [2:0] hist_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= 3'b111;
      end else begin
         hist_q <= {hist_q[1:0], rx_m_q};
      end
   end

   assign bit_s = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
   assign bit_s = rx_s_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m_q     <= 1'b1;
         rx_s_q     <= 1'b1;
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         rx_m_q     <= rx;
         rx_s_q     <= rx_m_q;
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
      end
   end

   // The counter is cleared at every terminal count and while parked, so it never wraps.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q + 16'd1;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            baud_cnt_d = '0;
            if (!rx_s_q) begin
               state_d = S_START;
            end
         end

         S_START: begin
            if (baud_cnt_q == HALF_LAST) begin
               baud_cnt_d = '0;
               if (bit_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_DATA;
                  bit_cnt_d = '0;
               end
            end
         end

         S_DATA: begin
            if (baud_cnt_q == DIV_LAST) begin
               shift_d    = {bit_s, shift_q[7:1]};
               baud_cnt_d = '0;
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end

         S_STOP: begin
            if (baud_cnt_q == DIV_LAST) begin
               data_d     = shift_q;
               baud_cnt_d = '0;
               if (bit_s) begin
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end

         // A line held low after a bad stop bit must go high before a new frame is considered.
         S_BREAK: begin
            baud_cnt_d = '0;
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d    = S_IDLE;
            baud_cnt_d = '0;
         end
      endcase
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != S_IDLE);

endmodule
